// File: rtl/dw_conv_pe.sv
// Depthwise-conv processing element: loads a KSIZE*KSIZE kernel, then produces one
// full-precision signed partial sum per activation window for NPIX windows per channel.
module dw_conv_pe #(
  parameter int DW    = 32,
  parameter int KSIZE = 3,
  parameter int NPIX  = 16,
  parameter int OW    = 68
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          clear,
  input  logic [DW-1:0] dw_out,
  input  logic          dw_comp,
  output logic          dw_ready,
  input  logic [DW-1:0] act_in,
  input  logic          act_valid,
  output logic          act_ready,
  output logic [OW-1:0] psum_out,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          ch_done
);

  localparam int KK = KSIZE * KSIZE;
  localparam int TW = (KK > 1) ? $clog2(KK) : 1;
  localparam int PW = (NPIX > 1) ? $clog2(NPIX) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, OUT} state_t;

  state_t state, next_state;

  logic [TW-1:0]        tap_idx;
  logic [PW-1:0]        pix_cnt;
  logic signed [OW-1:0] acc;
  logic [DW-1:0]        w_reg [KK];

  logic                   w_xfer, a_xfer, o_xfer;
  logic                   last_tap, last_pix;
  logic signed [2*DW-1:0] prod;
  logic signed [OW-1:0]   prod_ext, sum;

  assign dw_ready  = (state == LOAD);
  assign act_ready = (state == RUN);

  assign w_xfer   = dw_ready & dw_comp;
  assign a_xfer   = act_ready & act_valid;
  assign o_xfer   = (state == OUT) & out_ready;
  assign last_tap = (tap_idx == TW'(KK - 1));
  assign last_pix = (pix_cnt == PW'(NPIX - 1));

  // Both operands are sign-extended before the multiply so the product is exact.
  assign prod     = (2*DW)'($signed(w_reg[tap_idx])) * (2*DW)'($signed(act_in));
  assign prod_ext = OW'(prod);
  assign sum      = ((tap_idx == '0) ? {OW{1'b0}} : acc) + prod_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = LOAD;
      LOAD:    if (w_xfer && last_tap) next_state = RUN;
      RUN:     if (a_xfer && last_tap) next_state = OUT;
      OUT:     if (o_xfer) next_state = last_pix ? LOAD : RUN;
      default: next_state = IDLE;
    endcase
    if (clear) next_state = IDLE;
  end

  // psum_out is deliberately left alone by clear; only out_valid qualifies it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tap_idx   <= '0;
      pix_cnt   <= '0;
      acc       <= '0;
      psum_out  <= '0;
      out_valid <= 1'b0;
      ch_done   <= 1'b0;
      for (int i = 0; i < KK; i++) w_reg[i] <= '0;
    end else begin
      ch_done <= 1'b0;
      if (clear) begin
        tap_idx   <= '0;
        pix_cnt   <= '0;
        acc       <= '0;
        out_valid <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              tap_idx <= '0;
              pix_cnt <= '0;
            end
          end
          LOAD: begin
            if (w_xfer) begin
              w_reg[tap_idx] <= dw_out;
              tap_idx        <= last_tap ? '0 : tap_idx + TW'(1);
            end
          end
          RUN: begin
            if (a_xfer) begin
              acc     <= sum;
              tap_idx <= last_tap ? '0 : tap_idx + TW'(1);
              if (last_tap) begin
                psum_out  <= sum;
                out_valid <= 1'b1;
              end
            end
          end
          OUT: begin
            if (o_xfer) begin
              out_valid <= 1'b0;
              if (last_pix) begin
                ch_done <= 1'b1;
                pix_cnt <= '0;
                tap_idx <= '0;
              end else begin
                pix_cnt <= pix_cnt + PW'(1);
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
